mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MIPS memory stage: takes one load/store per handshake from EX, drives the data-memory bus,
//  aligns/extends load data into memory_out for the writeback mux, stalls the pipeline while busy.
//  Sits between EX and writeback; memory_out is the value writeback selects for loads.
// PARAMETERS
//  TIMEOUT_CYCLES  255  bus watchdog limit in cycles (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous reset, active-low
//  req_valid     in   1   EX presents a memory op
//  req_ready     out  1   unit can accept (state IDLE)
//  req_is_store  in   1   1=store, 0=load
//  req_size      in   2   mem_size_t: 00 byte, 01 half, 10 word (11 treated as word)
//  req_unsigned  in   1   zero-extend load (LBU/LHU)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data (low bytes significant)
//  dmem_req      out  1   bus request, held until dmem_gnt
//  dmem_we       out  1   write enable
//  dmem_addr     out  32  word address {req_addr[31:2],2'b00}
//  dmem_be       out  4   byte enables
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_gnt      in   1   request accepted this cycle
//  dmem_rvalid   in   1   read data valid
//  dmem_rdata    in   32  read data
//  memory_out    out  32  aligned/extended load result, held until next load completes
//  load_done     out  1   1-cycle pulse: memory_out updated
//  store_done    out  1   1-cycle pulse: store granted
//  misalign_err  out  1   1-cycle pulse: misaligned access, no bus traffic
//  bus_err       out  1   1-cycle pulse: watchdog abort
//  busy          out  1   stall to pipeline = !req_ready
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (req_ready=1, busy=0). Reset mid-op aborts, drops dmem_req.
//  FSM IDLE->REQ on req_valid&&req_ready; op fields latched. Misaligned (half addr[0]; word
//   addr[1:0]!=0): IDLE->DONE, misalign_err pulses, dmem_req never asserted.
//  REQ: dmem_req=1, bus fields stable. gnt: store->DONE (store_done next cycle); load->WAIT_R.
//  WAIT_R: rvalid -> register aligned data into memory_out, ->DONE. rvalid in IDLE/REQ ignored.
//  DONE: pulse asserted, ->IDLE (1 cycle). req_valid while busy ignored (not latched).
//  Min latency: accept c0, dmem_req c1 (gnt c1), rvalid c2, load_done+memory_out c3, next accept c4.
//  Store lanes: byte be=1<<a[1:0], wdata={4{b}}; half be=a[1]?1100:0011, wdata={2{h}}; word 1111.
//  Load: select byte/half by addr[1:0], sign-extend unless req_unsigned; word passes through.
//  memory_out unchanged by stores, misaligned ops, bus_err.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter clears on entering REQ, counts in REQ/WAIT_R, clears on
//   gnt; at TIMEOUT_CYCLES with no gnt/rvalid -> drop dmem_req, DONE, bus_err pulse.
//  Undefined: no counter, bus_err tied 0, unit waits indefinitely.
// STRUCTURE
//  Package mips_mem_pkg: mem_size_t, mem_state_t {IDLE,REQ,WAIT_R,DONE}, BE_* constants.
//  Sub-module load_align (combinational: rdata, addr[1:0], size, unsigned -> 32-bit result).
// TESTING
//  LB addr 0x103, rdata 0x80FF_FF7F -> memory_out 0xFFFF_FF80; LBU same -> 0x0000_0080.
//  SH addr 0x202 data 0x0000_BEEF -> dmem_be 1100, dmem_wdata 0xBEEF_BEEF, store_done once.
//  LW addr 0x301 -> misalign_err pulse c1, dmem_req stays 0, memory_out unchanged.
//  gnt withheld 5 cycles -> dmem_req/addr stable, busy=1 throughout, new req_valid ignored.
//  MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no gnt -> bus_err after 8 cycles, dmem_req drops.
//  rst_n low in WAIT_R -> all outputs 0 immediately; post-reset LW completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the MIPS memory stage
// Purpose: access size encoding, FSM state encoding, byte-enable constants
//          and the alignment check used by mem_access_unit.
// Ports:   none (package)
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11   // decoded exactly like SIZE_WORD
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    DONE   = 2'b11
  } mem_state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EX request handshake and data-memory bus bundle
// Purpose: groups the EX-side request signals and the dmem bus signals.
// Ports:   master = memory unit view (accepts requests, drives dmem bus)
//          slave  = environment view (EX stage plus data memory)
interface mem_access_unit_if;
  import mips_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  mem_size_t   req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport slave (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - load data lane select and extension
// Purpose: picks the addressed byte/half out of a read word and sign- or
//          zero-extends it; words pass through unchanged.
// Ports:   rdata_i (32) read word, addr_lo_i (2) byte offset, size_i access size,
//          unsigned_i zero-extend select, result_o (32) aligned result
import mips_mem_pkg::*;

module load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata_i[7:0];
    half_v   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    case (addr_lo_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    case (size_i)
      SIZE_BYTE: result_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SIZE_HALF: result_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default:   result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS memory stage: one load/store per handshake
// Purpose: accepts an op from EX, drives the data-memory bus, aligns load data
//          into memory_out and stalls the pipeline while an op is in flight.
// Ports:   clk, rst_n (async, active-low); bus (master modport: req_* handshake
//          from EX, dmem_* bus); memory_out (32) load result; load_done,
//          store_done, misalign_err, bus_err one-cycle pulses; busy stall.
// Config:  MEM_TIMEOUT_EN enables the TIMEOUT_CYCLES bus watchdog.
import mips_mem_pkg::*;

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.master     bus,
  output logic [31:0]           memory_out,
  output logic                  load_done,
  output logic                  store_done,
  output logic                  misalign_err,
  output logic                  bus_err,
  output logic                  busy
);

  mem_state_t  state_q;
  logic        is_store_q;
  mem_size_t   size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] dmem_wdata_q;
  logic [31:0] memory_out_q;
  logic        load_done_q;
  logic        store_done_q;
  logic        misalign_q;
  logic        bus_err_q;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_result;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Store data is replicated across lanes so the memory only needs byte enables.
  always_comb begin
    be_d    = BE_WORD;
    wdata_d = bus.req_wdata;
    case (bus.req_size)
      SIZE_BYTE: begin
        be_d    = BE_BYTE0 << bus.req_addr[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_d    = bus.req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata_i    (bus.dmem_rdata),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .result_o   (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_wdata_q <= 32'h0;
      memory_out_q <= 32'h0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q   <= bus.req_is_store;
            size_q       <= bus.req_size;
            unsigned_q   <= bus.req_unsigned;
            addr_lo_q    <= bus.req_addr[1:0];
            dmem_we_q    <= bus.req_is_store;
            dmem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            dmem_be_q    <= be_d;
            dmem_wdata_q <= wdata_d;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              // Misaligned ops never reach the bus.
              state_q    <= DONE;
              misalign_q <= 1'b1;
            end else begin
              state_q    <= REQ;
              dmem_req_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
              cnt_q      <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.dmem_gnt) begin
            dmem_req_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
            if (is_store_q) begin
              state_q      <= DONE;
              store_done_q <= 1'b1;
            end else begin
              state_q <= WAIT_R;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            dmem_req_q <= 1'b0;
            state_q    <= DONE;
            bus_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        WAIT_R: begin
          if (bus.dmem_rvalid) begin
            memory_out_q <= load_result;
            load_done_q  <= 1'b1;
            state_q      <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= DONE;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_be    = dmem_be_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign memory_out     = memory_out_q;
  assign load_done      = load_done_q;
  assign store_done     = store_done_q;
  assign misalign_err   = misalign_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
import mips_mem_pkg::*;

module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] memory_out;
  logic        load_done;
  logic        store_done;
  logic        misalign_err;
  logic        bus_err;
  logic        busy;
  int          n_assert;
  int          n_fail;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.master),
    .memory_out   (memory_out),
    .load_done    (load_done),
    .store_done   (store_done),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic st, input mem_size_t sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // Minimum-latency load: gnt in c1, rvalid in c2, result in c3, ready in c4.
  task automatic run_load(input string tag, input logic [31:0] addr, input mem_size_t sz,
                          input logic uns, input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp);
    chk1({tag, ".ready_c0"}, bus.req_ready, 1'b1);
    present(1'b0, sz, uns, addr, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk1({tag, ".req_c1"}, bus.dmem_req, 1'b1);
    chk1({tag, ".we_c1"}, bus.dmem_we, 1'b0);
    chk32({tag, ".addr_c1"}, bus.dmem_addr, exp_addr);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk1({tag, ".req_c2"}, bus.dmem_req, 1'b0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk1({tag, ".done_c3"}, load_done, 1'b1);
    chk32({tag, ".mout_c3"}, memory_out, exp);
    tick();
    chk1({tag, ".done_c4"}, load_done, 1'b0);
    chk1({tag, ".ready_c4"}, bus.req_ready, 1'b1);
  endtask

  task automatic run_store(input string tag, input logic [31:0] addr, input mem_size_t sz,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] mout_hold);
    present(1'b1, sz, 1'b0, addr, wdata);
    tick();
    bus.req_valid = 1'b0;
    chk1({tag, ".req_c1"}, bus.dmem_req, 1'b1);
    chk1({tag, ".we_c1"}, bus.dmem_we, 1'b1);
    chk32({tag, ".addr_c1"}, bus.dmem_addr, exp_addr);
    chk32({tag, ".be_c1"}, {28'h0, bus.dmem_be}, {28'h0, exp_be});
    chk32({tag, ".wdata_c1"}, bus.dmem_wdata, exp_wdata);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk1({tag, ".sdone_c2"}, store_done, 1'b1);
    chk1({tag, ".req_c2"}, bus.dmem_req, 1'b0);
    chk32({tag, ".mout_c2"}, memory_out, mout_hold);
    tick();
    chk1({tag, ".sdone_c3"}, store_done, 1'b0);
    chk1({tag, ".ready_c3"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_size     = SIZE_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.dmem_gnt     = 1'b0;
    bus.dmem_rvalid  = 1'b0;
    bus.dmem_rdata   = 32'h0;
    repeat (3) tick();

    chk1("rst.ready", bus.req_ready, 1'b1);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.dmem_req", bus.dmem_req, 1'b0);
    chk32("rst.dmem_wdata", bus.dmem_wdata, 32'h0);
    chk32("rst.mout", memory_out, 32'h0);
    chk1("rst.load_done", load_done, 1'b0);
    chk1("rst.bus_err", bus_err, 1'b0);
    rst_n = 1'b1;
    tick();

    run_load("lb", 32'h0000_0103, SIZE_BYTE, 1'b0, 32'h80FF_FF7F, 32'h0000_0100, 32'hFFFF_FF80);
    run_load("lbu", 32'h0000_0103, SIZE_BYTE, 1'b1, 32'h80FF_FF7F, 32'h0000_0100, 32'h0000_0080);
    run_load("lb1", 32'h0000_0101, SIZE_BYTE, 1'b0, 32'h0000_7F00, 32'h0000_0100, 32'h0000_007F);
    run_load("lh", 32'h0000_0102, SIZE_HALF, 1'b0, 32'h8001_1234, 32'h0000_0100, 32'hFFFF_8001);
    run_load("lhu", 32'h0000_0100, SIZE_HALF, 1'b1, 32'h8001_F234, 32'h0000_0100, 32'h0000_F234);
    run_load("lw", 32'h0000_0304, SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0000_0304, 32'hDEAD_BEEF);

    run_store("sh", 32'h0000_0202, SIZE_HALF, 32'h0000_BEEF, 32'h0000_0200, 4'b1100,
              32'hBEEF_BEEF, 32'hDEAD_BEEF);
    run_store("sb", 32'h0000_0401, SIZE_BYTE, 32'h1234_56A5, 32'h0000_0400, 4'b0010,
              32'hA5A5_A5A5, 32'hDEAD_BEEF);
    run_store("sw", 32'h0000_0408, SIZE_WORD_ALT, 32'h0102_0304, 32'h0000_0408, 4'b1111,
              32'h0102_0304, 32'hDEAD_BEEF);

    // Misaligned word load: error pulse in c1, bus untouched, result kept.
    present(1'b0, SIZE_WORD, 1'b0, 32'h0000_0301, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk1("mis.err_c1", misalign_err, 1'b1);
    chk1("mis.req_c1", bus.dmem_req, 1'b0);
    chk1("mis.busy_c1", busy, 1'b1);
    tick();
    chk1("mis.err_c2", misalign_err, 1'b0);
    chk1("mis.req_c2", bus.dmem_req, 1'b0);
    chk1("mis.ready_c2", bus.req_ready, 1'b1);
    chk32("mis.mout", memory_out, 32'hDEAD_BEEF);

    // Grant withheld 5 cycles; competing request and early rvalid must be ignored.
    present(1'b0, SIZE_WORD, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    present(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0600, 32'h0000_00FF);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      chk1("stall.req", bus.dmem_req, 1'b1);
      chk32("stall.addr", bus.dmem_addr, 32'h0000_0500);
      chk1("stall.we", bus.dmem_we, 1'b0);
      chk1("stall.busy", busy, 1'b1);
      chk1("stall.done", load_done, 1'b0);
      if (i == 4) begin
        bus.req_valid   = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_gnt    = 1'b1;
      end
      tick();
    end
    bus.dmem_gnt = 1'b0;
    chk1("stall.req_after_gnt", bus.dmem_req, 1'b0);
    chk32("stall.mout_wait", memory_out, 32'hDEAD_BEEF);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h5555_AAAA;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk1("stall.done", load_done, 1'b1);
    chk32("stall.mout", memory_out, 32'h5555_AAAA);
    tick();
    tick();
    chk1("stall.no_extra_req", bus.dmem_req, 1'b0);
    chk1("stall.idle", bus.req_ready, 1'b1);
    chk1("stall.bus_err", bus_err, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no grant for 8 REQ cycles aborts with bus_err.
    present(1'b0, SIZE_WORD, 1'b0, 32'h0000_0800, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("tmo.req", bus.dmem_req, 1'b1);
      chk1("tmo.err_early", bus_err, 1'b0);
      tick();
    end
    chk1("tmo.err", bus_err, 1'b1);
    chk1("tmo.req_drop", bus.dmem_req, 1'b0);
    tick();
    chk1("tmo.err_pulse", bus_err, 1'b0);
    chk1("tmo.ready", bus.req_ready, 1'b1);
    chk32("tmo.mout", memory_out, 32'h5555_AAAA);
`endif

    // Reset while waiting for read data.
    present(1'b0, SIZE_WORD, 1'b0, 32'h0000_0700, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    bus.dmem_gnt  = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk1("rstw.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rstw.ready", bus.req_ready, 1'b1);
    chk1("rstw.busy", busy, 1'b0);
    chk1("rstw.req", bus.dmem_req, 1'b0);
    chk32("rstw.addr", bus.dmem_addr, 32'h0);
    chk32("rstw.mout", memory_out, 32'h0);
    chk1("rstw.load_done", load_done, 1'b0);
    tick();
    rst_n = 1'b1;
    run_load("post_rst_lw", 32'h0000_0704, SIZE_WORD, 1'b0, 32'h1234_5678, 32'h0000_0704,
             32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
